// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 message-schedule expander:
//   WORD_W / BLOCK_W  - schedule word and padded block widths
//   WIN_DEPTH         - sliding window depth (16 words)
//   IDX_W             - width of the round index t
//   sched_state_e     - control FSM states (IDLE, RUN)
//   sigma0 / sigma1   - SHA-256 small sigma functions used by the expander
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int WIN_DEPTH = 16;
    localparam int IDX_W     = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0],  x[31:7]}
             ^ {x[17:0], x[31:18]}
             ^ {3'b000,  x[31:3]};
    endfunction

    // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0],        x[31:17]}
             ^ {x[18:0],        x[31:19]}
             ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/msg_sched_lane.sv
// msg_sched_lane
// One lane of the message schedule: a 16-word sliding window plus the
// next-word adder. window[0] is always the word currently presented.
//   clk, reset_n : clock, asynchronous active-low reset (clears the window)
//   load         : capture all 16 words of blk (word 0 = most significant)
//   shift        : advance the window one slot and append the next word
//   blk          : 512-bit padded block for this lane
//   word         : window[0], the current schedule word W[t]
module msg_sched_lane
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               shift,
    input  logic [BLOCK_W-1:0] blk,
    output logic [WORD_W-1:0]  word
);

    logic [WORD_W-1:0] window_reg [WIN_DEPTH];
    logic [WORD_W-1:0] new_word;

    // With window[0] = W[t], the slots map to W[t+i]; the word appended
    // for W[t+16] therefore uses W[t+14], W[t+9], W[t+1] and W[t].
    // Additions wrap modulo 2^32 by the 32-bit result width.
    assign new_word = sigma1(window_reg[14])
                    + window_reg[9]
                    + sigma0(window_reg[1])
                    + window_reg[0];

    generate
        for (genvar gi = 0; gi < WIN_DEPTH; gi++) begin : g_slot
            if (gi == WIN_DEPTH - 1) begin : g_tail
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        window_reg[gi] <= '0;
                    end else if (load) begin
                        window_reg[gi] <= blk[BLOCK_W-1-WORD_W*gi -: WORD_W];
                    end else if (shift) begin
                        window_reg[gi] <= new_word;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        window_reg[gi] <= '0;
                    end else if (load) begin
                        window_reg[gi] <= blk[BLOCK_W-1-WORD_W*gi -: WORD_W];
                    end else if (shift) begin
                        window_reg[gi] <= window_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    assign word = window_reg[0];

endmodule

// File: rtl/msg_schedule.sv
// msg_schedule
// Sequential SHA-256 message-schedule expander with LANES parallel lanes
// sharing one control path. A 512-bit block per lane is accepted in IDLE,
// then W[0]..W[NUM_ROUNDS-1] are streamed one word per lane per beat.
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : synchronous abort back to IDLE (highest priority)
//   blk_valid / blk_ready : block handshake; blk_data lane k at [512k+:512]
//   w_valid / w_ready     : word handshake; w_data lane k at [32k+:32]
//   w_index               : round index t of the presented word
//   w_last                : presented word is W[NUM_ROUNDS-1]
// All outputs come from registers or from state only, so there is no
// combinational path from w_ready or blk_valid to any output.
// Intended parameter ranges: LANES 1..8, NUM_ROUNDS 16..64.
module msg_schedule
    import sha256_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int NUM_ROUNDS = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic [LANES*BLOCK_W-1:0] blk_data,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [LANES*WORD_W-1:0]  w_data,
    output logic [IDX_W-1:0]         w_index,
    output logic                     w_last
);

    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(NUM_ROUNDS - 1);

    sched_state_e     state_reg, state_next;
    logic [IDX_W-1:0] t_reg, t_next;
    logic             blk_fire;
    logic             w_fire;
    logic             last_round;

    assign last_round = (t_reg == LAST_T);

    // ------------------------------------------------------------------
    // State and round counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. flush masks both handshakes, so a block offered
    // in the flush cycle is not captured and the windows do not shift.
    // t returns to 0 whenever the FSM re-enters IDLE, so w_index reads 0
    // between blocks for any NUM_ROUNDS.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        blk_fire   = 1'b0;
        w_fire     = 1'b0;
        if (flush) begin
            state_next = IDLE;
            t_next     = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (blk_valid) begin
                        blk_fire   = 1'b1;
                        state_next = RUN;
                        t_next     = '0;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        w_fire = 1'b1;
                        if (last_round) begin
                            state_next = IDLE;
                            t_next     = '0;
                        end else begin
                            t_next = t_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    t_next     = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state / registered counter
    // ------------------------------------------------------------------
    assign blk_ready = (state_reg == IDLE);
    assign w_valid   = (state_reg == RUN);
    assign w_index   = t_reg;
    assign w_last    = (state_reg == RUN) && last_round;

    // ------------------------------------------------------------------
    // Lane datapaths: identical windows driven by the shared handshakes
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            msg_sched_lane u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (blk_fire),
                .shift   (w_fire),
                .blk     (blk_data[gi*BLOCK_W +: BLOCK_W]),
                .word    (w_data[gi*WORD_W +: WORD_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule
// Directed bench for msg_schedule: a single-lane 64-round instance and a
// four-lane 48-round instance. Expected schedule words come from a
// reference SHA-256 schedule function written here in its textbook form.
module tb_msg_schedule;

    localparam int LB = 4;
    localparam int RB = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // single lane, 64 rounds
    logic         flush, blk_valid, blk_ready, w_valid, w_ready, w_last;
    logic [511:0] blk_data;
    logic [31:0]  w_data;
    logic [5:0]   w_index;

    // four lanes, 48 rounds
    logic              b_flush, b_blk_valid, b_blk_ready, b_w_valid, b_w_ready, b_w_last;
    logic [LB*512-1:0] b_blk_data;
    logic [LB*32-1:0]  b_w_data;
    logic [5:0]        b_w_index;

    int n_checks = 0;
    int n_fail   = 0;

    msg_schedule #(.LANES(1), .NUM_ROUNDS(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_index   (w_index),
        .w_last    (w_last)
    );

    msg_schedule #(.LANES(LB), .NUM_ROUNDS(RB)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (b_flush),
        .blk_valid (b_blk_valid),
        .blk_ready (b_blk_ready),
        .blk_data  (b_blk_data),
        .w_valid   (b_w_valid),
        .w_ready   (b_w_ready),
        .w_data    (b_w_data),
        .w_index   (b_w_index),
        .w_last    (b_w_last)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_w(input logic [511:0] blk, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
                 + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-16];
        end
        return w[t];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer blk to the single-lane instance and check every word it emits.
    // rnd=1 applies a random w_ready each cycle; stalled cycles are checked
    // against the same expected word, proving hold and no drop/duplicate.
    task automatic run_block(input logic [511:0] blk, input bit rnd, input string tag);
        int t;
        int cyc;
        logic [31:0] exp;
        check({tag, " idle w_valid"}, 32'(w_valid), 32'd0);
        check({tag, " idle blk_ready"}, 32'(blk_ready), 32'd1);
        blk_data  = blk;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        blk_data  = '0;
        t   = 0;
        cyc = 0;
        while (t < 64 && cyc < 1000) begin
            exp = ref_w(blk, t);
            check($sformatf("%s w_valid t=%0d", tag, t), 32'(w_valid), 32'd1);
            check($sformatf("%s blk_ready t=%0d", tag, t), 32'(blk_ready), 32'd0);
            check($sformatf("%s w_data t=%0d", tag, t), w_data, exp);
            check($sformatf("%s w_index t=%0d", tag, t), 32'(w_index), 32'(t));
            check($sformatf("%s w_last t=%0d", tag, t), 32'(w_last), 32'(t == 63));
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
            if (w_ready) t++;
        end
        if (cyc >= 1000) check({tag, " timeout"}, 32'(t), 32'd64);
        w_ready = 1'b1;
        check({tag, " end blk_ready"}, 32'(blk_ready), 32'd1);
        check({tag, " end w_valid"}, 32'(w_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [511:0] abc_blk, ones_blk, zero_blk, new_blk;
    logic [511:0] lane_blk [LB];

    initial begin
        abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
        ones_blk = {512{1'b1}};
        zero_blk = '0;
        for (int i = 0; i < 16; i++) new_blk[511-32*i -: 32] = 32'hA5A50000 + 32'(i * 7);

        flush = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b1;
        b_flush = 1'b0; b_blk_valid = 1'b0; b_blk_data = '0; b_w_ready = 1'b1;
        reset_n = 1'b0;
        #20;
        check("reset w_valid", 32'(w_valid), 32'd0);
        check("reset w_data", w_data, 32'd0);
        check("reset w_index", 32'(w_index), 32'd0);
        check("reset w_last", 32'(w_last), 32'd0);
        check("reset blk_ready", 32'(blk_ready), 32'd1);
        #2 reset_n = 1'b1;
        tick();

        // "abc" block, hand values for W16/W17 checked explicitly
        blk_data = abc_blk; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (t == 16) check("abc W16 hand", w_data, 32'h61626380);
            if (t == 17) check("abc W17 hand", w_data, 32'h000F0000);
            check($sformatf("abc w_data t=%0d", t), w_data, ref_w(abc_blk, t));
            check($sformatf("abc w_index t=%0d", t), 32'(w_index), 32'(t));
            check($sformatf("abc w_last t=%0d", t), 32'(w_last), 32'(t == 63));
            tick();
        end
        check("abc blk_ready n+65", 32'(blk_ready), 32'd1);
        check("abc w_valid n+65", 32'(w_valid), 32'd0);

        run_block(abc_blk, 1'b1, "abc-rnd");
        run_block(ones_blk, 1'b0, "ones");
        run_block(zero_blk, 1'b0, "zero");

        // flush on the t=20 handshake, with a coincident block offer
        blk_data = ones_blk; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (20) tick();
        check("flush pre w_index", 32'(w_index), 32'd20);
        check("flush pre w_data", w_data, ref_w(ones_blk, 20));
        flush = 1'b1; blk_valid = 1'b1; blk_data = new_blk;
        tick();
        flush = 1'b0; blk_valid = 1'b0;
        check("flush w_valid", 32'(w_valid), 32'd0);
        check("flush blk_ready", 32'(blk_ready), 32'd1);
        check("flush w_index", 32'(w_index), 32'd0);
        run_block(new_blk, 1'b0, "post-flush");

        // asynchronous reset at t=37
        blk_data = abc_blk; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (37) tick();
        check("rst pre w_index", 32'(w_index), 32'd37);
        #2 reset_n = 1'b0;
        #1;
        check("rst w_valid", 32'(w_valid), 32'd0);
        check("rst w_index", 32'(w_index), 32'd0);
        check("rst w_data", w_data, 32'd0);
        check("rst blk_ready", 32'(blk_ready), 32'd1);
        #10 reset_n = 1'b1;
        tick();
        run_block(abc_blk, 1'b0, "post-rst");

        // four lanes, 48 rounds
        for (int k = 0; k < LB; k++) begin
            for (int i = 0; i < 16; i++)
                lane_blk[k][511-32*i -: 32] = (32'h9E3779B9 * 32'(k + 1)) ^ (32'h01010101 * 32'(i));
            b_blk_data[k*512 +: 512] = lane_blk[k];
        end
        check("b idle blk_ready", 32'(b_blk_ready), 32'd1);
        b_blk_valid = 1'b1;
        tick();
        b_blk_valid = 1'b0;
        for (int t = 0; t < RB; t++) begin
            check($sformatf("b w_valid t=%0d", t), 32'(b_w_valid), 32'd1);
            check($sformatf("b w_index t=%0d", t), 32'(b_w_index), 32'(t));
            check($sformatf("b w_last t=%0d", t), 32'(b_w_last), 32'(t == RB - 1));
            for (int k = 0; k < LB; k++)
                check($sformatf("b lane%0d t=%0d", k, t), b_w_data[k*32 +: 32], ref_w(lane_blk[k], t));
            tick();
        end
        check("b blk_ready n+49", 32'(b_blk_ready), 32'd1);
        check("b w_valid n+49", 32'(b_w_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
